// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register with branch/jump resolution and stall-pending redirect (in: stall, id_valid, is_beq/bne/jump, equal, pc_plus4_id, imm_id, jump_index; out: pc, pc_plus4, flush, redirect_count)
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        is_jump,
  input  logic        equal,
  input  logic [31:0] pc_plus4_id,
  input  logic [15:0] imm_id,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic [15:0] redirect_count
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_nxt;
  logic [31:0] pend_target, pend_nxt, target, pc_nxt;
  logic dec_taken;
  always_comb begin
    dec_taken = id_valid & (is_jump | (is_beq & ~is_bne & equal) | (is_bne & ~is_beq & ~equal));
    target = is_jump ? {pc_plus4_id[31:28], jump_index, 2'b00}
                     : pc_plus4_id + {{14{imm_id[15]}}, imm_id, 2'b00};
    pc_plus4 = pc + 32'd4;
    flush = ~reset & ~stall & ((state == PENDING) | dec_taken);
    state_nxt = state;
    pend_nxt = pend_target;
    pc_nxt = pc;
    if (state == PENDING) begin
      pc_nxt = stall ? pc : pend_target;
      state_nxt = stall ? PENDING : IDLE;
    end else if (!stall) begin
      pc_nxt = dec_taken ? target : pc_plus4;
    end else if (dec_taken) begin
      pend_nxt = target;
      state_nxt = PENDING;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend_target <= 32'd0;
      redirect_count <= 16'd0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      pend_target <= pend_nxt;
      redirect_count <= redirect_count + 16'(flush);
    end
  end
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed self-checking bench for branch_pc_unit
module tb_branch_pc_unit;
  logic clk = 1'b0, reset = 1'b0, stall, id_valid, is_beq, is_bne, is_jump, equal;
  logic [31:0] pc_plus4_id, pc, pc_plus4;
  logic [15:0] imm_id, redirect_count;
  logic [25:0] jump_index;
  logic flush;
  int errors = 0, checks = 0;
  branch_pc_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .id_valid(id_valid), .is_beq(is_beq),
    .is_bne(is_bne), .is_jump(is_jump), .equal(equal), .pc_plus4_id(pc_plus4_id),
    .imm_id(imm_id), .jump_index(jump_index), .pc(pc), .pc_plus4(pc_plus4),
    .flush(flush), .redirect_count(redirect_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    stall = 0; id_valid = 0; is_beq = 0; is_bne = 0; is_jump = 0; equal = 0;
    pc_plus4_id = 0; imm_id = 0; jump_index = 0;
  endtask
  task automatic test_reset;
    clear_in();
    #2 reset = 1;
    #1;
    checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_async_pc got=%h exp=%h", pc, 32'h0040_0000); end
    checks++; if (redirect_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%h exp=0", redirect_count); end
    id_valid = 1; is_jump = 1;
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_hold_pc got=%h exp=%h", pc, 32'h0040_0000); end
    clear_in();
    reset = 0;
    #1;
    checks++; if (pc_plus4 !== 32'h0040_0004) begin errors++; $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, 32'h0040_0004); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'h0040_0000 + 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'h0040_0000 + 32'(4 * i)); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush%0d got=%b exp=0", i, flush); end
    end
    checks++; if (redirect_count !== 16'd0) begin errors++; $display("FAIL seq_count got=%h exp=0", redirect_count); end
  endtask
  task automatic test_beq;
    id_valid = 1; is_beq = 1; equal = 1; pc_plus4_id = 32'h0040_0010; imm_id = 16'hFFFC;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush got=%b exp=1", flush); end
    tick();
    checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL beq_pc got=%h exp=%h", pc, 32'h0040_0000); end
    checks++; if (redirect_count !== 16'd1) begin errors++; $display("FAIL beq_count got=%h exp=1", redirect_count); end
    equal = 0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_nt_flush got=%b exp=0", flush); end
    tick();
    checks++; if (pc !== 32'h0040_0004) begin errors++; $display("FAIL beq_nt_pc got=%h exp=%h", pc, 32'h0040_0004); end
    checks++; if (redirect_count !== 16'd1) begin errors++; $display("FAIL beq_nt_count got=%h exp=1", redirect_count); end
    clear_in();
  endtask
  task automatic test_bne;
    id_valid = 1; is_bne = 1; equal = 0; pc_plus4_id = 32'hFFFF_FFF0; imm_id = 16'h0008;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL bne_flush got=%b exp=1", flush); end
    tick();
    checks++; if (pc !== 32'h0000_0010) begin errors++; $display("FAIL bne_wrap_pc got=%h exp=%h", pc, 32'h0000_0010); end
    checks++; if (redirect_count !== 16'd2) begin errors++; $display("FAIL bne_count got=%h exp=2", redirect_count); end
    clear_in();
  endtask
  task automatic test_jump;
    id_valid = 1; is_jump = 1; pc_plus4_id = 32'h9000_0004; jump_index = 26'h000_0100;
    tick();
    checks++; if (pc !== 32'h9000_0400) begin errors++; $display("FAIL jump_pc got=%h exp=%h", pc, 32'h9000_0400); end
    is_beq = 1; equal = 1; imm_id = 16'h0010;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jump_prio_flush got=%b exp=1", flush); end
    tick();
    checks++; if (pc !== 32'h9000_0400) begin errors++; $display("FAIL jump_prio_pc got=%h exp=%h", pc, 32'h9000_0400); end
    checks++; if (redirect_count !== 16'd4) begin errors++; $display("FAIL jump_count got=%h exp=4", redirect_count); end
    is_jump = 0; is_bne = 1;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL both_br_flush got=%b exp=0", flush); end
    tick();
    checks++; if (pc !== 32'h9000_0404) begin errors++; $display("FAIL both_br_pc got=%h exp=%h", pc, 32'h9000_0404); end
    clear_in();
    is_jump = 1; pc_plus4_id = 32'h9000_0004; jump_index = 26'h000_0100;
    tick();
    checks++; if (pc !== 32'h9000_0408) begin errors++; $display("FAIL bubble_pc got=%h exp=%h", pc, 32'h9000_0408); end
    checks++; if (redirect_count !== 16'd4) begin errors++; $display("FAIL bubble_count got=%h exp=4", redirect_count); end
    clear_in();
  endtask
  task automatic test_stall;
    stall = 1;
    tick();
    checks++; if (pc !== 32'h9000_0408) begin errors++; $display("FAIL stall_idle_pc got=%h exp=%h", pc, 32'h9000_0408); end
    id_valid = 1; is_beq = 1; equal = 1; pc_plus4_id = 32'h0040_0010; imm_id = 16'hFFFC;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_flush%0d got=%b exp=0", i, flush); end
      tick();
      checks++; if (pc !== 32'h9000_0408) begin errors++; $display("FAIL stall_pc%0d got=%h exp=%h", i, pc, 32'h9000_0408); end
      imm_id = 16'h0100; is_jump = 1; jump_index = 26'h3FF_FFFF;
    end
    stall = 0;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL release_flush got=%b exp=1", flush); end
    clear_in();
    tick();
    checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL release_pc got=%h exp=%h", pc, 32'h0040_0000); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL release_flush_once got=%b exp=0", flush); end
    tick();
    checks++; if (pc !== 32'h0040_0004) begin errors++; $display("FAIL post_release_pc got=%h exp=%h", pc, 32'h0040_0004); end
    checks++; if (redirect_count !== 16'd5) begin errors++; $display("FAIL release_count got=%h exp=5", redirect_count); end
  endtask
  task automatic test_reset_pending;
    stall = 1; id_valid = 1; is_jump = 1; pc_plus4_id = 32'h9000_0004; jump_index = 26'h000_0100;
    tick();
    clear_in();
    stall = 1;
    #2 reset = 1;
    #1;
    checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL rst_pend_pc got=%h exp=%h", pc, 32'h0040_0000); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_pend_flush got=%b exp=0", flush); end
    checks++; if (redirect_count !== 16'd0) begin errors++; $display("FAIL rst_pend_count got=%h exp=0", redirect_count); end
    tick();
    reset = 0; stall = 0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stale_flush got=%b exp=0", flush); end
    tick();
    checks++; if (pc !== 32'h0040_0004) begin errors++; $display("FAIL stale_pc got=%h exp=%h", pc, 32'h0040_0004); end
    checks++; if (redirect_count !== 16'd0) begin errors++; $display("FAIL stale_count got=%h exp=0", redirect_count); end
  endtask
  initial begin
    test_reset();
    test_beq();
    test_bne();
    test_jump();
    test_stall();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter register and branch-resolution stage of the MIPS pipeline. It sits directly downstream of the ID-stage 32-bit equality comparator. It consumes the comparator's single-bit `equal` result together with the decoded branch/jump controls, and decides whether control flow redirects. It then updates the PC, flushes the IF/ID register on a redirect, and holds a pending redirect across pipeline stalls.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard-unit freeze; PC and the ID instruction hold while high.
- `id_valid`  in  1  the ID stage holds a real instruction (not a bubble).
- `is_beq`  in  1  the ID instruction is BEQ.
- `is_bne`  in  1  the ID instruction is BNE.
- `is_jump`  in  1  the ID instruction is J or JAL.
- `equal`  in  1  comparator result: rs value == rt value.
- `pc_plus4_id`  in  32  PC+4 of the instruction in ID.
- `imm_id`  in  16  branch offset field.
- `jump_index`  in  26  jump target field.
- `pc`  out  32  current fetch PC (registered).
- `pc_plus4`  out  32  `pc` + 4, modulo 2^32 (combinational).
- `flush`  out  1  clears IF/ID on the same edge that loads a redirect target.
- `redirect_count`  out  16  number of redirects taken (registered).

## Operation
- Decision, combinational:
  - `dec_taken` = `id_valid` & (`is_jump` | (`is_beq` & ~`is_bne` & `equal`) | (`is_bne` & ~`is_beq` & ~`equal`)).
  - If `is_beq` and `is_bne` are both high without `is_jump`, no redirect occurs.
  - `is_jump` has priority over the branch inputs.
- Target, combinational:
  - Jump: {`pc_plus4_id`[31:28], `jump_index`, 2'b00}.
  - Branch: `pc_plus4_id` + ({{14{imm_id[15]}}, imm_id, 2'b00}). The sum is 32-bit, carry discarded, so it wraps modulo 2^32.
- State machine, two states:
  - IDLE:
    - `stall`=0 & `dec_taken`: `pc` <= target, `flush`=1, count += 1, stay IDLE.
    - `stall`=0 & ~`dec_taken`: `pc` <= `pc`+4, `flush`=0.
    - `stall`=1 & `dec_taken`: `pend_target` <= target, go to PENDING, `pc` holds, `flush`=0.
    - `stall`=1 & ~`dec_taken`: `pc` holds.
  - PENDING:
    - Decision inputs are ignored. The frozen ID instruction is re-presented each cycle and must not re-arm or overwrite `pend_target`.
    - `stall`=1: hold everything.
    - `stall`=0: `pc` <= `pend_target`, `flush`=1, count += 1, go to IDLE.
- `flush` is combinational from the state and inputs: high only in a cycle whose rising edge loads a redirect target.
- `redirect_count` wraps from 16'hFFFF to 0.
- Reset, asynchronous, any state:
  - `pc`=`RESET_PC`, state=IDLE, `pend_target`=0, `redirect_count`=0.
  - `flush`=0 while `reset` is high.
  - Any pending redirect is discarded.

## Timing
- Redirect latency: a decision in cycle N with `stall`=0 gives `pc`=target in cycle N+1. `flush` is high during cycle N.
- Stalled redirect: a decision in cycle N with `stall` high through cycle N+k, then low in cycle N+k+1, gives `pc`=target in cycle N+k+2. `flush` is high only in cycle N+k+1.
- Sequential fetch: `pc` advances by 4 every unstalled cycle. 32'hFFFF_FFFC wraps to 0.
- Reset release: the first edge with `reset` low and `stall`=0 gives `pc`=`RESET_PC`+4, unless a redirect is taken.
- `stall` high always blocks PC update and `flush`, including in IDLE with a taken decision.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, then 3 unstalled cycles with no branch -> `pc` = 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; `flush`=0; count=0.
- BEQ, `equal`=1, `pc_plus4_id`=0x0040_0010, `imm_id`=16'hFFFC -> `flush`=1 that cycle, next `pc`=0x0040_0000, count=1. Same stimulus with `equal`=0 -> `pc`+4, no flush.
- BNE, `equal`=0, `pc_plus4_id`=0xFFFF_FFF0, `imm_id`=16'h0008 -> `pc`=0x0000_0010 (wrap).
- J with `pc_plus4_id`=0x9000_0004, `jump_index`=26'h000_0100 -> `pc`=0x9000_0400. Repeat with `is_beq`=1 also set: jump still wins.
- Taken BEQ with `stall`=1 for 3 cycles, then `stall`=0:
  - While stalled: `pc` holds, `flush`=0, and changing `imm_id` does not alter the target.
  - After release: a single `flush` pulse, `pc`=original target, count +1 only once.
- Assert `reset` mid-PENDING (asynchronously, between edges) -> `pc`=`RESET_PC` immediately, `flush`=0. After release, no stale redirect occurs.
